// File: rtl/sync_sep_pkg.sv
// Shared types and default 24 MHz PAL timing for the composite sync separator.
package sync_sep_pkg;

  localparam int TMR_W = 16;

  localparam int PAL_HSYNC_CYC     = 113;
  localparam int PAL_VSYNC_MIN_CYC = 240;
  localparam int PAL_LINE_CYC      = 1536;
  localparam int PAL_GUARD_CYC     = 64;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    PORCH  = 2'd2,
    ACTIVE = 2'd3
  } state_t;

endpackage

// File: rtl/sync_deglitch.sv
// Sync-tip comparator with a saturating up/down hysteresis counter.
module sync_deglitch #(
  parameter int DATA_W   = 6,
  parameter int THRESH   = 10,
  parameter int DEGLITCH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce,
  input  logic [DATA_W-1:0] cvbs,
  output logic              sync_lvl
);

  localparam int CNT_W = $clog2(DEGLITCH + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEGLITCH);
  localparam logic [DATA_W-1:0] THR     = DATA_W'(THRESH);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             low;

  assign low = (cvbs < THR);

  // Counter moves one step toward the comparator result, clamped to 0..DEGLITCH.
  always_comb begin
    cnt_d = cnt_q;
    if (low && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!low && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // sync_lvl only flips at the counter extremes, so short glitches never toggle it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      sync_lvl <= 1'b0;
    end else if (ce) begin
      cnt_q <= cnt_d;
      if (cnt_d == CNT_MAX) begin
        sync_lvl <= 1'b1;
      end else if (cnt_d == '0) begin
        sync_lvl <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sync_separator.sv
// Composite-video sync separator: hsync/vsync, back-porch black level, line lock.
//
// state  | meaning
// SEARCH | waiting for a sync_lvl rise, line timeout armed
// SYNC   | inside a sync pulse, measuring its width
// PORCH  | averaging 2^BL_SHIFT back-porch samples
// ACTIVE | active video, sync_lvl ignored until the lock window opens
module sync_separator
  import sync_sep_pkg::*;
#(
  parameter int DATA_W        = 6,
  parameter int THRESH        = 10,
  parameter int DEGLITCH      = 8,
  parameter int HSYNC_CYC     = PAL_HSYNC_CYC,
  parameter int VSYNC_MIN_CYC = PAL_VSYNC_MIN_CYC,
  parameter int BROAD_CNT     = 3,
  parameter int LINE_CYC      = PAL_LINE_CYC,
  parameter int GUARD_CYC     = PAL_GUARD_CYC,
  parameter int BL_SHIFT      = 7,
  parameter int LOCK_LINES    = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce,
  input  logic [DATA_W-1:0] cvbs,
  output logic              hsync_n,
  output logic              vsync_n,
  output logic [DATA_W-1:0] blacklevel,
  output logic              locked,
  output logic              error
);

  localparam int ACC_W = DATA_W + BL_SHIFT;
  localparam int LK_W  = $clog2(LOCK_LINES + 1);
  localparam int BR_W  = $clog2(BROAD_CNT + 1);

  localparam logic [TMR_W-1:0] WIN_LO    = TMR_W'(LINE_CYC - GUARD_CYC);
  localparam logic [TMR_W-1:0] WIN_HI    = TMR_W'(LINE_CYC + GUARD_CYC);
  localparam logic [TMR_W-1:0] LINE_END  = TMR_W'(LINE_CYC);
  localparam logic [TMR_W-1:0] HS_LOAD   = TMR_W'(HSYNC_CYC);
  localparam logic [TMR_W-1:0] BROAD_MIN = TMR_W'(VSYNC_MIN_CYC);
  localparam logic [LK_W-1:0]  LOCK_MAX  = LK_W'(LOCK_LINES);
  localparam logic [LK_W-1:0]  LOCK_PRE  = LK_W'(LOCK_LINES - 1);
  localparam logic [BR_W-1:0]  BROAD_MAX = BR_W'(BROAD_CNT);
  localparam logic [BR_W-1:0]  BROAD_PRE = BR_W'(BROAD_CNT - 1);

  state_t state_q, state_d;

  logic               sync_lvl, sync_lvl_d, rise;
  logic [TMR_W-1:0]   line_tmr, width, hs_tmr;
  logic [LK_W-1:0]    lock_cnt;
  logic [BR_W-1:0]    broad_cnt;
  logic [ACC_W-1:0]   accu, acc_sum;
  logic [BL_SHIFT-1:0] n_cnt;
  logic               first_edge;
  logic               in_window, is_broad;
  logic               acc_rise, search_tout, sync_tout, pulse_end, porch_last, porch_step;

  sync_deglitch #(
    .DATA_W  (DATA_W),
    .THRESH  (THRESH),
    .DEGLITCH(DEGLITCH)
  ) u_deglitch (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .cvbs    (cvbs),
    .sync_lvl(sync_lvl)
  );

  assign rise      = sync_lvl & ~sync_lvl_d;
  assign in_window = (line_tmr >= WIN_LO) && (line_tmr <= WIN_HI);
  assign is_broad  = (width >= BROAD_MIN);
  assign acc_sum   = accu + ACC_W'(cvbs);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= SEARCH;
    else          state_q <= state_d;
  end

  // Next state and per-cycle event strobes; a rise in SEARCH beats a timeout.
  always_comb begin
    state_d     = state_q;
    acc_rise    = 1'b0;
    search_tout = 1'b0;
    sync_tout   = 1'b0;
    pulse_end   = 1'b0;
    porch_last  = 1'b0;
    porch_step  = 1'b0;
    if (ce) begin
      case (state_q)
        SEARCH: begin
          if (rise) begin
            acc_rise = 1'b1;
            state_d  = SYNC;
          end else if (line_tmr == WIN_HI) begin
            search_tout = 1'b1;
          end
        end
        SYNC: begin
          if (!sync_lvl) begin
            pulse_end = 1'b1;
            state_d   = is_broad ? ACTIVE : PORCH;
          end else if (line_tmr == LINE_END) begin
            sync_tout = 1'b1;
            state_d   = SEARCH;
          end
        end
        PORCH: begin
          if (rise) begin
            state_d = ACTIVE;
          end else begin
            porch_step = 1'b1;
            if (n_cnt == '1) begin
              porch_last = 1'b1;
              state_d    = ACTIVE;
            end
          end
        end
        ACTIVE: begin
          if (line_tmr >= WIN_LO) state_d = SEARCH;
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // Timers, lock/broad counters, porch accumulator and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_lvl_d <= 1'b0;
      line_tmr   <= '0;
      width      <= '0;
      hs_tmr     <= '0;
      lock_cnt   <= '0;
      broad_cnt  <= '0;
      accu       <= '0;
      n_cnt      <= '0;
      first_edge <= 1'b1;
      hsync_n    <= 1'b1;
      vsync_n    <= 1'b1;
      blacklevel <= '0;
      locked     <= 1'b0;
      error      <= 1'b0;
    end else begin
      error <= 1'b0;
      if (ce) begin
        sync_lvl_d <= sync_lvl;

        if (acc_rise || search_tout) line_tmr <= '0;
        else if (line_tmr != '1)     line_tmr <= line_tmr + TMR_W'(1);

        if (acc_rise) begin
          hs_tmr  <= HS_LOAD;
          hsync_n <= 1'b0;
        end else if (hs_tmr != '0) begin
          hs_tmr <= hs_tmr - TMR_W'(1);
          if (hs_tmr == TMR_W'(1)) hsync_n <= 1'b1;
        end

        if (acc_rise) width <= '0;
        else if ((state_q == SYNC) && sync_lvl && (width != '1)) width <= width + TMR_W'(1);

        if (acc_rise) begin
          first_edge <= 1'b0;
          if (!first_edge) begin
            if (in_window) begin
              if (lock_cnt != LOCK_MAX) lock_cnt <= lock_cnt + LK_W'(1);
              if (lock_cnt == LOCK_PRE) locked <= 1'b1;
            end else begin
              error    <= 1'b1;
              lock_cnt <= '0;
              locked   <= 1'b0;
            end
          end
        end

        if (search_tout) begin
          error    <= 1'b1;
          lock_cnt <= '0;
          locked   <= 1'b0;
        end
        if (sync_tout) error <= 1'b1;

        if (pulse_end) begin
          if (is_broad) begin
            if (broad_cnt != BROAD_MAX) broad_cnt <= broad_cnt + BR_W'(1);
            if (broad_cnt >= BROAD_PRE) vsync_n <= 1'b0;
          end else begin
            broad_cnt <= '0;
            vsync_n   <= 1'b1;
            accu      <= '0;
            n_cnt     <= '0;
          end
        end

        if (porch_step) begin
          accu  <= acc_sum;
          n_cnt <= n_cnt + BL_SHIFT'(1);
          if (porch_last) blacklevel <= acc_sum[ACC_W-1:BL_SHIFT];
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_separator.sv
// Line-level stimulus with a timestamp-based reference model of sync, lock and error events.
module tb_sync_separator;

  localparam int DATA_W        = 6;
  localparam int THRESH        = 10;
  localparam int DEGLITCH      = 8;
  localparam int HSYNC_CYC     = 113;
  localparam int VSYNC_MIN_CYC = 240;
  localparam int BROAD_CNT     = 3;
  localparam int LINE_CYC      = 1536;
  localparam int GUARD_CYC     = 64;
  localparam int BL_SHIFT      = 7;
  localparam int LOCK_LINES    = 4;
  localparam int WIN_LO        = LINE_CYC - GUARD_CYC;
  localparam int WIN_HI        = LINE_CYC + GUARD_CYC;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              ce;
  logic [DATA_W-1:0] cvbs;
  logic              hsync_n, vsync_n, locked, error;
  logic [DATA_W-1:0] blacklevel;

  sync_separator #(
    .DATA_W(DATA_W), .THRESH(THRESH), .DEGLITCH(DEGLITCH), .HSYNC_CYC(HSYNC_CYC),
    .VSYNC_MIN_CYC(VSYNC_MIN_CYC), .BROAD_CNT(BROAD_CNT), .LINE_CYC(LINE_CYC),
    .GUARD_CYC(GUARD_CYC), .BL_SHIFT(BL_SHIFT), .LOCK_LINES(LOCK_LINES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .cvbs(cvbs),
    .hsync_n(hsync_n), .vsync_n(vsync_n), .blacklevel(blacklevel),
    .locked(locked), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ce_cnt = 0;
  int err_act[$];
  int err_exp[$];

  // Model state: ce index at which line_tmr last read zero, lock and vsync bookkeeping.
  int ref_ce, lock_m, broad_m, black_m, last_rise;
  bit first_m, locked_m, vsync_m, model_on;

  always @(posedge clk) if (ce === 1'b1 && reset_n === 1'b1) ce_cnt++;
  always @(negedge clk) if (error === 1'b1) err_act.push_back(ce_cnt);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_timeouts(input int upto);
    while (ref_ce + WIN_HI + 1 <= upto) begin
      ref_ce += WIN_HI + 1;
      err_exp.push_back(ref_ce);
      lock_m   = 0;
      locked_m = 0;
    end
  endfunction

  function automatic void model_rise(input int r);
    int tmr;
    model_timeouts(r - 1);
    tmr = r - ref_ce - 1;
    if (first_m) begin
      first_m = 0;
    end else if (tmr >= WIN_LO && tmr <= WIN_HI) begin
      if (lock_m < LOCK_LINES) lock_m++;
      if (lock_m == LOCK_LINES) locked_m = 1;
    end else begin
      err_exp.push_back(r);
      lock_m   = 0;
      locked_m = 0;
    end
    ref_ce    = r;
    last_rise = r;
  endfunction

  task automatic compare_errors(input string tag);
    int n;
    @(negedge clk); #1;
    model_timeouts(ce_cnt);
    check({tag, "_err_count"}, err_act.size(), err_exp.size());
    n = (err_act.size() < err_exp.size()) ? err_act.size() : err_exp.size();
    for (int i = 0; i < n; i++) check({tag, "_err_at"}, err_act[i], err_exp[i]);
    err_act.delete();
    err_exp.delete();
  endtask

  task automatic do_reset();
    ce = 1'b0;
    cvbs = DATA_W'(30);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hsync", hsync_n, 1);
    check("rst_vsync", vsync_n, 1);
    check("rst_black", blacklevel, 0);
    check("rst_locked", locked, 0);
    check("rst_error", error, 0);
    @(negedge clk);
    reset_n = 1'b1;
    ref_ce = ce_cnt;
    first_m = 1; lock_m = 0; locked_m = 0; vsync_m = 1; broad_m = 0; black_m = 0;
    err_act.delete();
    err_exp.delete();
  endtask

  task automatic run_const(input int n, input int lvl);
    for (int k = 0; k < n; k++) begin
      cvbs = DATA_W'(lvl);
      ce = 1'b1;
      @(posedge clk); #1;
      check("idle_hsync", hsync_n, 1);
    end
  endtask

  task automatic run_line(input int period, input int tip_len, input int tip_lvl,
                          input int porch_lvl, input int glitch_at, input int spike_at,
                          input int stall_at, input int abort_at, input bit chk);
    int v;
    int expv;
    expv = 1;
    for (int k = 0; k < period; k++) begin
      if (k == abort_at) return;
      if (k == stall_at) begin
        ce = 1'b0;
        repeat (10) begin
          @(posedge clk); #1;
          if (chk) check("stall_hsync", hsync_n, expv);
          check("stall_error", error, 0);
        end
      end
      v = (k < tip_len) ? tip_lvl : porch_lvl;
      if (glitch_at >= 0 && k >= glitch_at && k < glitch_at + 5) v = tip_lvl;
      if (spike_at >= 0 && k >= spike_at && k < spike_at + 5) v = porch_lvl;
      cvbs = DATA_W'(v);
      ce = 1'b1;
      @(posedge clk); #1;
      if (k == DEGLITCH && model_on) model_rise(ce_cnt);
      expv = (k >= DEGLITCH && k < DEGLITCH + HSYNC_CYC) ? 0 : 1;
      if (chk) check("hsync", hsync_n, expv);
    end
    if (model_on) begin
      if (tip_len >= VSYNC_MIN_CYC) begin
        if (broad_m < BROAD_CNT) broad_m++;
        if (broad_m >= BROAD_CNT) vsync_m = 0;
      end else begin
        broad_m = 0;
        vsync_m = 1;
        black_m = porch_lvl;
      end
      check("line_vsync", vsync_n, vsync_m);
      check("line_black", blacklevel, black_m);
      check("line_locked", locked, locked_m);
      compare_errors("line");
    end
  endtask

  initial begin
    int per, tl, tv, pl, gl, tgt;
    model_on = 1;
    do_reset();

    // Clean PAL lines with a mid-active glitch and a spike inside one sync tip.
    for (int i = 0; i < 6; i++)
      run_line(LINE_CYC, 113, 2, 20, (i == 2) ? 800 : -1, (i == 3) ? 50 : -1, -1, -1, 1);
    check("pal_locked", locked, 1);
    check("pal_black", blacklevel, 20);

    // Randomised in-window lines.
    for (int i = 0; i < 8; i++) begin
      per = $urandom_range(1590, 1480);
      tl  = $urandom_range(140, 90);
      tv  = $urandom_range(THRESH - 1, 0);
      pl  = $urandom_range(50, 12);
      gl  = ($urandom_range(1, 0) == 1) ? $urandom_range(1300, 600) : -1;
      run_line(per, tl, tv, pl, gl, -1, -1, -1, 1);
    end

    // Three broad pulses, then normal lines.
    for (int i = 0; i < 3; i++) run_line(LINE_CYC, 650, 2, 20, -1, -1, -1, -1, 1);
    check("broad_vsync", vsync_n, 0);
    for (int i = 0; i < 2; i++) run_line(LINE_CYC, 113, 2, 33, -1, -1, -1, -1, 1);
    check("post_broad_vsync", vsync_n, 1);

    // ce held low for 10 clocks inside the hsync pulse.
    run_line(LINE_CYC, 113, 2, 25, -1, -1, 50, -1, 1);

    // Syncs removed: three timeouts, then syncs restored.
    tgt = last_rise + 3 * (WIN_HI + 1) + 100;
    run_const(tgt - ce_cnt, 30);
    check("tout_errs", err_act.size(), 3);
    compare_errors("tout");
    check("tout_locked", locked, 0);
    for (int i = 0; i < 6; i++) run_line(LINE_CYC, 113, 2, 20, -1, -1, -1, -1, 1);
    check("relock", locked, 1);

    // Short 1400-cycle lines never qualify for lock.
    model_on = 0;
    err_act.delete();
    for (int i = 0; i < 6; i++) begin
      run_line(1400, 113, 2, 20, -1, -1, -1, -1, 0);
      if (i > 0) check("p1400_locked", locked, 0);
    end
    check("p1400_errs", (err_act.size() >= 4) ? 1 : 0, 1);

    // 1500-cycle lines, reset in the middle of a porch measurement.
    do_reset();
    model_on = 1;
    for (int i = 0; i < 2; i++) run_line(1500, 113, 2, 20, -1, -1, -1, -1, 1);
    run_line(1500, 113, 2, 20, -1, -1, -1, 200, 1);
    do_reset();
    run_const(1300, 20);
    check("post_rst_black", blacklevel, 0);
    for (int i = 0; i < 6; i++) run_line(1500, 113, 2, 20, -1, -1, -1, -1, 1);
    check("p1500_locked", locked, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
